reg_universal_desplazamiento: RTL and testbench

//  Parametrised universal register: parallel load, shift right, shift left or hold,

---
 rtl/reg_pkg.sv | 21 ++
 rtl/celda_universal.sv | 44 ++++
 rtl/reg_universal_desplazamiento.sv | 90 +++++++++
 tb/tb_reg_universal_desplazamiento.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// ============================================================================
// Module  : reg_pkg
// Purpose : Mode encodings shared by the universal shift register and its cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_pkg;

  localparam logic [1:0] MODO_HOLD = 2'b00;
  localparam logic [1:0] MODO_SHR  = 2'b01;
  localparam logic [1:0] MODO_SHL  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  function automatic logic es_desplazamiento(input logic [1:0] modo);
    return (modo == MODO_SHR) || (modo == MODO_SHL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/celda_universal.sv
// ============================================================================
// Module  : celda_universal
// Purpose : One register bit: 4:1 mux (hold/right/left/load) into an async-reset FFD.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module celda_universal
  import reg_pkg::*;
(
  input  logic       reloj,
  input  logic       despeje_reset,
  input  logic       en,
  input  logic [1:0] modo,
  input  logic       d_der,
  input  logic       d_izq,
  input  logic       d_carga,
  output logic       q
);

  logic w_d;

  always_comb begin
    w_d = q;
    case (modo)
      MODO_HOLD: w_d = q;
      MODO_SHR:  w_d = d_der;
      MODO_SHL:  w_d = d_izq;
      MODO_LOAD: w_d = d_carga;
      default:   w_d = q;
    endcase
  end

  always_ff @(posedge reloj or posedge despeje_reset) begin
    if (despeje_reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= w_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_universal_desplazamiento.sv
// ============================================================================
// Module  : reg_universal_desplazamiento
// Purpose : Universal register (hold/shift right/shift left/load) with a saturating
//           shift counter. Optional rotate input under macro REG_ROTATE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_universal_desplazamiento
  import reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             reloj,
  input  logic             despeje_reset,
  input  logic             en,
  input  logic [1:0]       modo,
  input  logic             ser_msb,
  input  logic             ser_lsb,
  input  logic [WIDTH-1:0] In,
`ifdef REG_ROTATE_EN
  input  logic             rotar,
`endif
  output logic [WIDTH-1:0] An,
  output logic             sal_lsb,
  output logic             sal_msb,
  output logic [CW-1:0]    cuenta,
  output logic             lista
);

  localparam logic [CW-1:0] C_LLENO = CW'(WIDTH);

  logic             w_ent_msb;
  logic             w_ent_lsb;
  logic [WIDTH-1:0] w_vec_der;
  logic [WIDTH-1:0] w_vec_izq;
  logic [CW-1:0]    r_cuenta;
  logic             r_lista;

`ifdef REG_ROTATE_EN
  assign w_ent_msb = rotar ? An[0]       : ser_msb;
  assign w_ent_lsb = rotar ? An[WIDTH-1] : ser_lsb;
`else
  assign w_ent_msb = ser_msb;
  assign w_ent_lsb = ser_lsb;
`endif

  // Per-bit next value for each shift direction, including the serial end bit.
  assign w_vec_der = {w_ent_msb, An[WIDTH-1:1]};
  assign w_vec_izq = {An[WIDTH-2:0], w_ent_lsb};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_celda
      celda_universal u_celda (
        .reloj         (reloj),
        .despeje_reset (despeje_reset),
        .en            (en),
        .modo          (modo),
        .d_der         (w_vec_der[i]),
        .d_izq         (w_vec_izq[i]),
        .d_carga       (In[i]),
        .q             (An[i])
      );
    end
  endgenerate

  always_ff @(posedge reloj or posedge despeje_reset) begin
    if (despeje_reset) begin
      r_cuenta <= '0;
      r_lista  <= 1'b0;
    end else if (en) begin
      if (modo == MODO_LOAD) begin
        r_cuenta <= '0;
        r_lista  <= 1'b0;
      end else if (es_desplazamiento(modo) && (r_cuenta != C_LLENO)) begin
        r_cuenta <= r_cuenta + CW'(1);
        r_lista  <= (r_cuenta + CW'(1)) == C_LLENO;
      end
    end
  end

  assign cuenta  = r_cuenta;
  assign lista   = r_lista;
  assign sal_lsb = An[0];
  assign sal_msb = An[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_reg_universal_desplazamiento.sv
// ============================================================================
// Module  : tb_reg_universal_desplazamiento
// Purpose : Directed self-checking bench for the 4-bit universal shift register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_universal_desplazamiento;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             reloj = 1'b0;
  logic             despeje_reset;
  logic             en;
  logic [1:0]       modo;
  logic             ser_msb;
  logic             ser_lsb;
  logic [WIDTH-1:0] In;
  logic             rotar;
  logic [WIDTH-1:0] An;
  logic             sal_lsb;
  logic             sal_msb;
  logic [CW-1:0]    cuenta;
  logic             lista;

  int r_tests = 0;
  int r_fails = 0;

  logic [3:0] c_seq_lsb = 4'b1011;

  reg_universal_desplazamiento #(.WIDTH(WIDTH)) dut (
    .reloj         (reloj),
    .despeje_reset (despeje_reset),
    .en            (en),
    .modo          (modo),
    .ser_msb       (ser_msb),
    .ser_lsb       (ser_lsb),
    .In            (In),
`ifdef REG_ROTATE_EN
    .rotar         (rotar),
`endif
    .An            (An),
    .sal_lsb       (sal_lsb),
    .sal_msb       (sal_msb),
    .cuenta        (cuenta),
    .lista         (lista)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_tests++;
    if (obs !== exp) begin
      r_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  initial begin
    despeje_reset = 1'b1;
    en = 1'b0; modo = 2'b00; ser_msb = 1'b0; ser_lsb = 1'b0;
    In = '0; rotar = 1'b0;
    tick();
    despeje_reset = 1'b0;
    chk("reset_an", An, 4'b0000);

    // Async clear mid-cycle from 1010, no clock edge involved.
    en = 1'b1; modo = 2'b11; In = 4'b1010;
    tick();
    chk("load_1010", An, 4'b1010);
    modo = 2'b01;
    #2 despeje_reset = 1'b1;
    #1;
    chk("async_an", An, 4'b0000);
    chk("async_cuenta", cuenta, 0);
    chk("async_lista", lista, 0);
    modo = 2'b11;
    tick();
    chk("reset_hold_an", An, 4'b0000);
    despeje_reset = 1'b0;

    // Load then freeze with en=0.
    In = 4'b1011; modo = 2'b11;
    tick();
    chk("load_1011", An, 4'b1011);
    chk("load_cuenta", cuenta, 0);
    en = 1'b0; modo = 2'b01;
    repeat (3) tick();
    chk("en0_an", An, 4'b1011);
    chk("en0_cuenta", cuenta, 0);

    // Shift right four times; bits leave LSB first: 1,1,0,1.
    en = 1'b1; ser_msb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("shr_sal_lsb", sal_lsb, c_seq_lsb[k]);
      tick();
      chk("shr_cuenta", cuenta, k + 1);
      if (k < 3) chk("shr_lista_low", lista, 0);
    end
    chk("shr4_an", An, 4'b0000);
    chk("shr4_lista", lista, 1);

    // Saturation, then load clears the counter.
    tick();
    chk("sat_cuenta", cuenta, 4);
    chk("sat_lista", lista, 1);
    modo = 2'b11; In = 4'b0110;
    tick();
    chk("reload_an", An, 4'b0110);
    chk("reload_cuenta", cuenta, 0);
    chk("reload_lista", lista, 0);

    // Shift left from 0001 with ser_lsb=1.
    In = 4'b0001;
    tick();
    modo = 2'b10; ser_lsb = 1'b1;
    tick();
    chk("shl1_an", An, 4'b0011);
    tick();
    chk("shl2_an", An, 4'b0111);
    chk("shl2_sal_msb", sal_msb, 0);
    chk("shl2_cuenta", cuenta, 2);
    modo = 2'b00;
    repeat (2) tick();
    chk("hold_an", An, 4'b0111);
    chk("hold_cuenta", cuenta, 2);

    // Direction change keeps counting.
    modo = 2'b01; ser_msb = 1'b1;
    tick();
    chk("mixed_an", An, 4'b1011);
    chk("mixed_cuenta", cuenta, 3);
    chk("mixed_sal_msb", sal_msb, 1);
    modo = 2'b10; ser_lsb = 1'b0;
    tick();
    chk("mixed_full_an", An, 4'b0110);
    chk("mixed_full_lista", lista, 1);

`ifdef REG_ROTATE_EN
    rotar = 1'b1; ser_msb = 1'b0; ser_lsb = 1'b0;
    modo = 2'b11; In = 4'b1000;
    tick();
    modo = 2'b10;
    tick();
    chk("rot_shl_an", An, 4'b0001);
    modo = 2'b01;
    tick();
    chk("rot_shr_an", An, 4'b1000);
    chk("rot_cuenta", cuenta, 2);
    rotar = 1'b0;
`endif

    // Reset mid-shift discards the word.
    modo = 2'b01; ser_msb = 1'b1;
    #2 despeje_reset = 1'b1;
    #1;
    chk("midshift_an", An, 4'b0000);
    chk("midshift_cuenta", cuenta, 0);
    despeje_reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

endmodule

`default_nettype wire
